stick_mode_ctrl: RTL and testbench



---
 rtl/stick_mode_ctrl_pkg.sv | 24 ++
 rtl/stick_mode_ctrl_debounce.sv | 59 +++++
 rtl/stick_mode_ctrl.sv | 150 +++++++++++++++
 tb/tb_stick_mode_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stick_mode_ctrl_pkg.sv
// Shared definitions for the light-stick mode controller.
// Mode encodings are used by the controller and the LED bank.
package stick_mode_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_SOLID = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_CHASE = 2'd3
   } mode_t;

   // Button presses walk the modes in a fixed ring.
   function automatic mode_t mode_next(input mode_t m);
      mode_t r;
      unique case (m)
         MODE_OFF:   r = MODE_SOLID;
         MODE_SOLID: r = MODE_BLINK;
         MODE_BLINK: r = MODE_CHASE;
         MODE_CHASE: r = MODE_OFF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/stick_mode_ctrl_debounce.sv
// Button synchroniser, stability filter and rising-edge detector.
// press is a registered one-cycle pulse per debounced rising edge.
module btn_debounce #(
   parameter int DEB_CYC = 4
) (
   input  logic clock,
   input  logic clr_n,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEB_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_press;

   logic w_diff;
   logic w_done;

   assign w_diff = r_sync2 ^ r_level;
   assign w_done = w_diff && (r_cnt == LAST);

   // Two-flop synchroniser for the asynchronous button.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
      end
   end

   // Level follows the input only after an unbroken run of mismatches.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else begin
         r_press <= w_done & r_sync2;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign press = r_press;

endmodule

// File: rtl/stick_mode_ctrl.sv
// Mode controller for the light-stick LED register bank.
// Owns the mode FSM, the step prescaler and the bank control word.
module stick_mode_ctrl
   import stick_mode_ctrl_pkg::*;
#(
   parameter int N_LED    = 8,
   parameter int DIV_W    = 16,
   parameter int TICK_DIV = 50000,
   parameter int DEB_CYC  = 4
) (
   input  logic             clock,
   input  logic             clr_n,
   input  logic             btn,
   input  logic [1:0]       speed,
   output logic [1:0]       mode,
   output logic [N_LED-1:0] led_d,
   output logic             led_load,
   output logic             led_pre,
   output logic             led_clr
);

   localparam logic [DIV_W-1:0] TC   = DIV_W'(TICK_DIV - 1);
   localparam logic [N_LED-1:0] ONES = '1;
   localparam logic [N_LED-1:0] SEED = N_LED'(1);

   mode_t            r_mode;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_sub;
   logic [N_LED-1:0] r_led;
   logic             r_load;
   logic             r_pre;
   logic             r_clr;

   logic             w_press;
   logic             w_tick;
   logic             w_step;
   mode_t            w_mode_nxt;
   logic [DIV_W-1:0] w_div_nxt;
   logic [1:0]       w_sub_nxt;
   logic [N_LED-1:0] w_led_nxt;
   logic             w_load_nxt;
   logic             w_pre_nxt;
   logic             w_clr_nxt;

   btn_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_deb (
      .clock (clock),
      .clr_n (clr_n),
      .btn   (btn),
      .press (w_press)
   );

   assign w_tick = (r_div == TC);
   assign w_step = w_tick && (r_sub >= speed);

   // Next mode, prescaler and bank word; a press overrides any step.
   always_comb begin
      w_mode_nxt = r_mode;
      w_div_nxt  = w_tick ? '0 : r_div + DIV_W'(1);
      w_sub_nxt  = r_sub;
      w_led_nxt  = r_led;
      w_load_nxt = 1'b0;
      w_pre_nxt  = 1'b0;
      w_clr_nxt  = 1'b0;
      if (w_tick) begin
         w_sub_nxt = w_step ? 2'd0 : r_sub + 2'd1;
      end
      if (w_press) begin
         w_mode_nxt = mode_next(r_mode);
         w_div_nxt  = '0;
         w_sub_nxt  = 2'd0;
         unique case (w_mode_nxt)
            MODE_OFF: begin
               w_clr_nxt = 1'b1;
               w_led_nxt = '0;
            end
            MODE_SOLID: begin
               w_pre_nxt = 1'b1;
               w_led_nxt = ONES;
            end
            MODE_BLINK: begin
               w_load_nxt = 1'b1;
               w_led_nxt  = ONES;
            end
            MODE_CHASE: begin
               w_load_nxt = 1'b1;
               w_led_nxt  = SEED;
            end
         endcase
      end else if (w_step) begin
         unique case (r_mode)
            MODE_OFF: begin
            end
            MODE_SOLID: begin
            end
            MODE_BLINK: begin
               w_load_nxt = 1'b1;
               w_led_nxt  = ~r_led;
            end
            MODE_CHASE: begin
               w_load_nxt = 1'b1;
               w_led_nxt  = {r_led[N_LED-2:0], r_led[N_LED-1]};
            end
         endcase
      end
   end

   // Mode state register.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         r_mode <= MODE_OFF;
      end else begin
         r_mode <= w_mode_nxt;
      end
   end

   // Base tick counter and tick sub-counter.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         r_div <= '0;
         r_sub <= 2'd0;
      end else begin
         r_div <= w_div_nxt;
         r_sub <= w_sub_nxt;
      end
   end

   // Registered bank controls; clear is held while in reset.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         r_led  <= '0;
         r_load <= 1'b0;
         r_pre  <= 1'b0;
         r_clr  <= 1'b1;
      end else begin
         r_led  <= w_led_nxt;
         r_load <= w_load_nxt;
         r_pre  <= w_pre_nxt;
         r_clr  <= w_clr_nxt;
      end
   end

   assign mode     = r_mode;
   assign led_d    = r_led;
   assign led_load = r_load;
   assign led_pre  = r_pre;
   assign led_clr  = r_clr;

endmodule

// File: tb/tb_stick_mode_ctrl.sv
// Bench for stick_mode_ctrl: directed scenarios, then random presses
// and speeds, all checked against a step-count reference model.
module tb_stick_mode_ctrl;

   localparam int N  = 4;
   localparam int TD = 3;
   localparam int DC = 4;

   logic         clock = 1'b0;
   logic         clr_n = 1'b0;
   logic         btn   = 1'b0;
   logic [1:0]   speed = 2'd0;
   logic [1:0]   mode;
   logic [N-1:0] led_d;
   logic         led_load;
   logic         led_pre;
   logic         led_clr;

   int n_vec = 0;
   int n_err = 0;

   // Model: mode, cycles since origin (entry or re-base),
   // steps already taken at the origin, speed in force.
   int m_mode = 0;
   int m_t    = 0;
   int m_k0   = 0;
   int m_spd  = 0;

   always #5 clock = ~clock;

   stick_mode_ctrl #(
      .N_LED    (N),
      .DIV_W    (16),
      .TICK_DIV (TD),
      .DEB_CYC  (DC)
   ) dut (
      .clock    (clock),
      .clr_n    (clr_n),
      .btn      (btn),
      .speed    (speed),
      .mode     (mode),
      .led_d    (led_d),
      .led_load (led_load),
      .led_pre  (led_pre),
      .led_clr  (led_clr)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int p;
      int s;
      int e_led;
      int e_load;
      int e_pre;
      int e_clr;
      p      = TD * (m_spd + 1);
      s      = m_k0 + m_t / p;
      e_load = (m_mode >= 2 && (m_t % p) == 0) ? 1 : 0;
      e_pre  = (m_mode == 1 && m_t == 0) ? 1 : 0;
      e_clr  = (m_mode == 0 && m_t == 0) ? 1 : 0;
      case (m_mode)
         0:       e_led = 0;
         1:       e_led = (1 << N) - 1;
         2:       e_led = (s % 2 == 1) ? 0 : (1 << N) - 1;
         default: e_led = 1 << (s % N);
      endcase
      chk("mode", 32'(mode), 32'(m_mode));
      chk("led_d", 32'(led_d), 32'(e_led));
      chk("led_load", 32'(led_load), 32'(e_load));
      chk("led_pre", 32'(led_pre), 32'(e_pre));
      chk("led_clr", 32'(led_clr), 32'(e_clr));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      m_t++;
   endtask

   task automatic step_chk(input int n);
      repeat (n) begin
         step();
         check_all();
      end
   endtask

   // Clean press: btn high reaches the mode on the 7th edge,
   // then release and let the debouncer settle low again.
   task automatic do_press();
      btn = 1'b1;
      step_chk(2 + DC);
      step();
      m_mode = (m_mode + 1) % 4;
      m_t    = 0;
      m_k0   = 0;
      check_all();
      btn = 1'b0;
      step_chk(2 + DC);
   endtask

   initial begin
      int d;

      // Reset values while clr_n is low.
      repeat (2) @(posedge clock);
      #1;
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_led", 32'(led_d), 32'd0);
      chk("rst_load", 32'(led_load), 32'd0);
      chk("rst_pre", 32'(led_pre), 32'd0);
      chk("rst_clr", 32'(led_clr), 32'd1);
      clr_n = 1'b1;
      check_all();
      step_chk(3);

      // Bounce: single-cycle highs never survive the filter.
      btn = 1'b1; step_chk(1);
      btn = 1'b0; step_chk(1);
      btn = 1'b1; step_chk(1);
      btn = 1'b0; step_chk(1);
      step_chk(4);
      do_press();

      // BLINK at speed 2, then drop to speed 0 with sub-count 1.
      speed = 2'd2;
      m_spd = 2;
      do_press();
      while (m_t < 21) step_chk(1);
      speed = 2'd0;
      step_chk(2);
      step();
      m_t   = 0;
      m_k0  = 3;
      m_spd = 0;
      check_all();
      chk("blink_fast_toggle", 32'(led_d), 32'd0);
      step_chk(7);

      // CHASE at speed 0 through a full wrap.
      do_press();
      while (m_t < 16) step_chk(1);

      // Asynchronous reset mid-period in CHASE.
      #2;
      clr_n = 1'b0;
      #1;
      chk("arst_mode", 32'(mode), 32'd0);
      chk("arst_led", 32'(led_d), 32'd0);
      chk("arst_clr", 32'(led_clr), 32'd1);
      chk("arst_load", 32'(led_load), 32'd0);
      chk("arst_pre", 32'(led_pre), 32'd0);
      @(posedge clock);
      #1;
      chk("arst_hold_clr", 32'(led_clr), 32'd1);
      chk("arst_hold_led", 32'(led_d), 32'd0);
      clr_n  = 1'b1;
      m_mode = 0;
      m_t    = 0;
      m_k0   = 0;
      check_all();
      step_chk(4);

      // Mode wrap: four presses back to OFF.
      repeat (4) do_press();
      chk("wrap_mode", 32'(mode), 32'd0);

      // Press lands on a CHASE step edge.
      repeat (3) do_press();
      while (m_t < 8) step_chk(1);
      do_press();
      chk("collide_mode", 32'(mode), 32'd0);

      // Random dwell lengths and speeds.
      for (int it = 0; it < 14; it++) begin
         if (m_mode < 2) begin
            m_spd = int'($urandom_range(0, 3));
            speed = 2'(m_spd);
         end
         d = int'($urandom_range(0, 30));
         step_chk(d);
         do_press();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
